// File: rtl/sensor_seq_gen_pkg.sv
// Shared state encoding and (a,b) phase tables for the sensor sequence generator.
// Used by sensor_seq_gen and phase_timer.
package sensor_seq_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        GAP  = 3'd4
    } state_e;

    localparam int TIMER_W = 8;

    // Entry [0] is P1 ... entry [3] is GAP; each entry is {a,b}
    localparam logic [3:0][1:0] SUMAR_TAB  = {2'b00, 2'b10, 2'b11, 2'b01};
    localparam logic [3:0][1:0] RESTAR_TAB = {2'b00, 2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] phase_ab(input logic restar, input state_e s);
        logic [1:0] idx;
        logic [1:0] ab;
        idx = 2'(3'(s) - 3'd1);
        ab  = restar ? RESTAR_TAB[idx] : SUMAR_TAB[idx];
        if (s == IDLE) ab = 2'b00;
        return ab;
    endfunction

endpackage

// File: rtl/sensor_seq_gen_phase_timer.sv
// Phase timer: counts 0..PHASE_CYCLES-1, cleared by load.
// expired flags the last cycle of the current phase.
module phase_timer
    import sensor_seq_gen_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    output logic               expired,
    output logic [TIMER_W-1:0] count
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(PHASE_CYCLES - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (load || expired) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);
    assign count   = cnt_q;

endmodule

// File: rtl/sensor_seq_gen.sv
// Quadrature-style sensor emulator: plays sumar/restar (a,b) sequences.
// Optional net event counter enabled by SENSOR_SEQ_GEN_COUNT_EN.
module sensor_seq_gen
    import sensor_seq_gen_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_sumar,
    input  logic req_restar,
    output logic a,
    output logic b,
    output logic busy,
    output logic done
`ifdef SENSOR_SEQ_GEN_COUNT_EN
    ,
    output logic signed [7:0] evt_count
`endif
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(PHASE_CYCLES - 1);

    state_e state_q, state_d;
    logic   dir_q, dir_d;
    logic   a_q, a_d;
    logic   b_q, b_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic               load;
    logic               expired;
    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] cnt_next;

    phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expired(expired),
        .count  (count)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (req_sumar ^ req_restar) begin
                    state_d = P1;
                    dir_d   = req_restar;
                end
            end
            P1:      if (expired) state_d = P2;
            P2:      if (expired) state_d = P3;
            P3:      if (expired) state_d = GAP;
            GAP:     if (expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        load     = (state_q == IDLE) || expired;
        cnt_next = load ? '0 : count + 8'd1;

        {a_d, b_d} = phase_ab(dir_d, state_d);
        busy_d     = (state_d != IDLE);
        // done is registered, so look one cycle ahead at the timer
        done_d     = (state_d == GAP) && (cnt_next == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef SENSOR_SEQ_GEN_COUNT_EN
    logic signed [7:0] evt_q, evt_d;

    always_comb begin
        evt_d = evt_q;
        if (done_q) evt_d = dir_q ? evt_q - 8'sd1 : evt_q + 8'sd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) evt_q <= '0;
        else      evt_q <= evt_d;
    end

    assign evt_count = evt_q;
`endif

endmodule

// File: tb/tb_sensor_seq_gen.sv
// Self-checking bench for sensor_seq_gen: PHASE_CYCLES=4 and =1 instances
// against a cycle-offset reference model plus directed literal checks.
module tb_sensor_seq_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_sumar = 1'b0;
    logic req_restar = 1'b0;
    logic a0, b0, busy0, done0;
    logic a1, b1, busy1, done1;
`ifdef SENSOR_SEQ_GEN_COUNT_EN
    logic signed [7:0] evt0, evt1;
`endif

    always #5 clk = ~clk;

    sensor_seq_gen #(.PHASE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_sumar(req_sumar), .req_restar(req_restar),
        .a(a0), .b(b0), .busy(busy0), .done(done0)
`ifdef SENSOR_SEQ_GEN_COUNT_EN
        , .evt_count(evt0)
`endif
    );

    sensor_seq_gen #(.PHASE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_sumar(req_sumar), .req_restar(req_restar),
        .a(a1), .b(b1), .busy(busy1), .done(done1)
`ifdef SENSOR_SEQ_GEN_COUNT_EN
        , .evt_count(evt1)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Reference: sequence position k since acceptance; phase = k / PHASE_CYCLES
    int  pc[2] = '{4, 1};
    bit  act[2];
    bit  mdir[2];
    int  k[2];
    byte mcnt[2];
    bit  en = 1'b0;
    bit  s_s, s_r, s_rst;
    logic [3:0] got_v, exp_v;

    function automatic logic [1:0] exp_ab(input bit restar, input int ph);
        logic [1:0] v;
        case (ph)
            0:       v = restar ? 2'b10 : 2'b01;
            1:       v = 2'b11;
            2:       v = restar ? 2'b01 : 2'b10;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    always begin
        @(posedge clk);
        s_s = req_sumar;
        s_r = req_restar;
        s_rst = rst;
        for (int i = 0; i < 2; i++) begin
            if (!s_rst) begin
                act[i]  = 1'b0;
                mcnt[i] = 8'sd0;
            end else if (!act[i]) begin
                if (s_s != s_r) begin
                    act[i]  = 1'b1;
                    mdir[i] = s_r;
                    k[i]    = 0;
                end
            end else begin
                if (k[i] == 4 * pc[i] - 1) mcnt[i] = mdir[i] ? mcnt[i] - 8'sd1 : mcnt[i] + 8'sd1;
                k[i]++;
                if (k[i] == 4 * pc[i]) act[i] = 1'b0;
            end
        end
        if (!s_rst) en = 1'b1;
        #1;
        if (en) begin
            for (int i = 0; i < 2; i++) begin
                exp_v = act[i] ? {exp_ab(mdir[i], k[i] / pc[i]), 1'b1, k[i] == 4 * pc[i] - 1}
                               : 4'b0000;
                got_v = (i == 0) ? {a0, b0, busy0, done0} : {a1, b1, busy1, done1};
                chk(i == 0 ? "model_abbd_pc4" : "model_abbd_pc1", int'(got_v), int'(exp_v));
`ifdef SENSOR_SEQ_GEN_COUNT_EN
                chk(i == 0 ? "model_cnt_pc4" : "model_cnt_pc1",
                    (i == 0) ? int'(evt0) : int'(evt1), int'(mcnt[i]));
`endif
            end
        end
    end

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    int n;

    initial begin
        do_reset();
        chk("reset_pc4", int'({a0, b0, busy0, done0}), 0);
        chk("reset_pc1", int'({a1, b1, busy1, done1}), 0);
        step(2);

        // Sumar on PHASE_CYCLES=4
        req_sumar = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            step(1);
            if (j == 1) req_sumar = 1'b0;
            case (j)
                1:  chk("sumar_t1_ab", int'({a0, b0}), 1);
                4:  chk("sumar_t4_ab", int'({a0, b0}), 1);
                5:  chk("sumar_t5_ab", int'({a0, b0}), 3);
                9:  chk("sumar_t9_ab", int'({a0, b0}), 2);
                13: chk("sumar_t13_abbusy", int'({a0, b0, busy0}), 1);
                15: chk("sumar_t15_done", int'(done0), 0);
                16: chk("sumar_t16_done", int'(done0), 1);
                17: chk("sumar_t17_busy", int'(busy0), 0);
                default: ;
            endcase
        end
        step(3);

        // Restar on PHASE_CYCLES=1
        req_restar = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step(1);
            if (j == 1) req_restar = 1'b0;
            case (j)
                1: chk("restar_t1_ab", int'({a1, b1}), 2);
                2: chk("restar_t2_ab", int'({a1, b1}), 3);
                3: chk("restar_t3_ab", int'({a1, b1}), 1);
                4: chk("restar_t4_abdone", int'({a1, b1, done1}), 1);
                5: chk("restar_t5_busy", int'(busy1), 0);
                default: ;
            endcase
        end
        step(16);

        // Simultaneous requests are ignored
        req_sumar  = 1'b1;
        req_restar = 1'b1;
        step(1);
        req_sumar  = 1'b0;
        req_restar = 1'b0;
        chk("both_busy_ab_pc4", int'({a0, b0, busy0}), 0);
        chk("both_busy_ab_pc1", int'({a1, b1, busy1}), 0);
        step(1);
        chk("both_stay_idle", int'({busy0, busy1}), 0);

        // Reset mid-sequence, then restart cleanly
        req_sumar = 1'b1;
        n = 0;
        for (int j = 1; j <= 9; j++) begin
            step(1);
            if (done0) n++;
            case (j)
                1: req_sumar = 1'b0;
                6: rst = 1'b0;
                7: begin
                    chk("rst_mid_outputs", int'({a0, b0, busy0, done0}), 0);
                    rst = 1'b1;
                end
                8: req_sumar = 1'b1;
                9: begin
                    req_sumar = 1'b0;
                    chk("rst_restart_ab_busy", int'({a0, b0, busy0}), 3'b011);
                end
                default: ;
            endcase
        end
        chk("rst_mid_no_done", n, 0);
        step(20);

        // Request while busy is dropped
        req_sumar = 1'b1;
        n = 0;
        for (int j = 1; j <= 30; j++) begin
            step(1);
            if (j == 1) req_sumar = 1'b0;
            if (j == 3) req_restar = 1'b1;
            if (j == 4) req_restar = 1'b0;
            if (j == 5) chk("busy_ignore_t5_ab", int'({a0, b0}), 3);
            if (done0) n++;
        end
        chk("busy_ignore_one_seq", n, 1);
        chk("busy_ignore_idle", int'(busy0), 0);

`ifdef SENSOR_SEQ_GEN_COUNT_EN
        do_reset();
        chk("cnt_reset", int'(evt0), 0);
        for (int q = 0; q < 4; q++) begin
            if (q < 3) req_sumar = 1'b1;
            else       req_restar = 1'b1;
            step(1);
            req_sumar  = 1'b0;
            req_restar = 1'b0;
            step(20);
        end
        chk("cnt_3s1r_pc4", int'(evt0), 2);
        chk("cnt_3s1r_pc1", int'(evt1), 2);

        do_reset();
        req_sumar = 1'b1;
        n = 0;
        for (int j = 0; j < 2000 && n < 127; j++) begin
            step(1);
            if (done1) n++;
        end
        req_sumar = 1'b0;
        chk("cnt_wrap_seq_count", n, 127);
        step(20);
        chk("cnt_at_127", int'(evt1), 127);
        req_sumar = 1'b1;
        step(1);
        req_sumar = 1'b0;
        step(10);
        chk("cnt_wrap_neg128", int'(evt1), -128);
        step(20);
`endif

        // Random traffic against the model
        for (int j = 0; j < 3000; j++) begin
            step(1);
            rst        = ($urandom_range(0, 63) != 0);
            req_sumar  = ($urandom_range(0, 3) == 0);
            req_restar = ($urandom_range(0, 3) == 0);
        end
        rst        = 1'b1;
        req_sumar  = 1'b0;
        req_restar = 1'b0;
        step(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
